// File: rtl/memory_stage_pkg.sv
// Shared control-word layout and M-stage FSM encodings for the memory stage.
package memory_stage_pkg;

   localparam int CTRL_W         = 12;
   localparam int CTRL_MEM_READ  = 0;
   localparam int CTRL_MEM_WRITE = 1;

   typedef enum logic [1:0] {
      M_IDLE   = 2'd0,
      M_ACCESS = 2'd1,
      M_DONE   = 2'd2
   } mstate_e;

   function automatic logic is_mem_op(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEM_READ] | ctrl[CTRL_MEM_WRITE];
   endfunction

   // Read+write together is illegal and resolves to a load.
   function automatic logic is_store(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEM_WRITE] & ~ctrl[CTRL_MEM_READ];
   endfunction

endpackage

// File: rtl/memory_stage_register.sv
// Plain enabled register with synchronous active-high clear.
module memory_stage_register #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   // Clear has priority over the load enable.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/memory_stage.sv
// Memory stage: runs a req/ack data-memory access for loads/stores, stalls
// upstream while it is outstanding and bubbles the MW latch meanwhile.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  M_IDLE   | no access; non-memory ops pass straight through
//  M_ACCESS | dmem_req held; waiting for dmem_ack or the timeout count
//  M_DONE   | access finished; XM inputs plus captured load data go to MW
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = 32'h0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wren,
   input  logic [31:0]       in_ALU_result,
   input  logic [31:0]       in_store_data,
   input  logic [4:0]        in_rd,
   input  logic [CTRL_W-1:0] in_ctrl_signals,
   output logic [31:0]       dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic              dmem_req,
   output logic              dmem_we,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              stall,
   output logic              mem_error,
   output logic [31:0]       out_ALU_result,
   output logic [31:0]       out_data_read,
   output logic [4:0]        out_rd,
   output logic [CTRL_W-1:0] out_ctrl_signals,
   output logic              mw_wren
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mstate_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             cap;
   logic [31:0]      cap_data;
   logic [31:0]      rdata_q;
   logic             mem_op, store;

   assign mem_op = is_mem_op(in_ctrl_signals);
   assign store  = is_store(in_ctrl_signals);

   // State, timeout count and sticky error; wren=0 freezes everything.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= M_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else if (wren) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next state, count and load-data capture; ack beats a same-cycle timeout.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      cap      = 1'b0;
      cap_data = ERR_DATA;
      case (state_q)
         M_IDLE: begin
            if (mem_op) begin
               state_d = M_ACCESS;
               cnt_d   = '0;
            end
         end
         M_ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (dmem_ack) begin
               cap      = 1'b1;
               cap_data = store ? 32'h0 : dmem_rdata;
               state_d  = M_DONE;
            end else if (cnt_q == CNT_LAST) begin
               cap     = 1'b1;
               err_d   = 1'b1;
               state_d = M_DONE;
            end
         end
         M_DONE:  state_d = M_IDLE;
         default: state_d = M_IDLE;
      endcase
   end

   memory_stage_register #(.W(32)) u_rdata (
      .clk_i (clock),
      .rst_i (~reset),
      .en_i  (cap & wren),
      .d_i   (cap_data),
      .q_o   (rdata_q)
   );

   // Output decode; everything but the address/data lines is forced low in reset.
   always_comb begin
      dmem_addr        = in_ALU_result;
      dmem_wdata       = in_store_data;
      dmem_req         = reset & (state_q == M_ACCESS);
      dmem_we          = reset & (state_q == M_ACCESS) & store;
      stall            = reset & (((state_q == M_IDLE) & mem_op) | (state_q == M_ACCESS));
      mem_error        = reset & err_q;
      mw_wren          = reset & wren;
      out_ALU_result   = 32'h0;
      out_data_read    = 32'h0;
      out_rd           = 5'd0;
      out_ctrl_signals = '0;
      if (reset && !stall) begin
         out_ALU_result   = in_ALU_result;
         out_rd           = in_rd;
         out_ctrl_signals = in_ctrl_signals;
         out_data_read    = (state_q == M_DONE) ? rdata_q : 32'h0;
      end
   end

endmodule
